pipeline_ctrl: RTL

//  Central stall/flush/forward/PC controller for the 5-stage core (F-D-E-M-W), replacing the fixed

---
 rtl/pipeline_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/forward/PC controller for the 5-stage F-D-E-M-W core.
// A redirect that arrives while the pipe is frozen is parked in pend and applied once it thaws.
module pipeline_ctrl #(
  parameter int unsigned    PCW      = 32,
  parameter int unsigned    RAW      = 6,
  parameter logic [PCW-1:0] RESET_PC = '0,
  parameter int unsigned    PC_STEP  = 4,
  parameter bit             ZERO_REG = 1'b1,
  parameter int unsigned    CNTW     = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [RAW-1:0]  rs0_d,
  input  logic [RAW-1:0]  rs1_d,
  input  logic [RAW-1:0]  rd_e,
  input  logic            regwrite_e,
  input  logic            memread_e,
  input  logic [RAW-1:0]  rd_m,
  input  logic            regwrite_m,
  input  logic            exec_busy,
  input  logic            mem_busy,
  input  logic            redirect_valid,
  input  logic [PCW-1:0]  redirect_pc,
  output logic [PCW-1:0]  pc,
  output logic            fetch_en,
  output logic            decode_en,
  output logic            exec_en,
  output logic            mem_en,
  output logic            decode_flush,
  output logic            exec_flush,
  output logic            mem_bubble,
  output logic            wb_bubble,
  output logic [1:0]      forward0,
  output logic [1:0]      forward1,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);
  logic           pend_v;
  logic [PCW-1:0] pend_pc;
  logic           frozen, redir, lwstall, lw, run, stalled;
  function automatic logic match(input logic [RAW-1:0] rs, input logic [RAW-1:0] rd);
    return rs == rd && !(ZERO_REG && rs == '0);
  endfunction
  function automatic logic [1:0] fwd(input logic [RAW-1:0] rs);
    return (regwrite_e && !memread_e && match(rs, rd_e)) ? 2'b01 :
           (regwrite_m && match(rs, rd_m)) ? 2'b10 : 2'b00;
  endfunction
  always_comb begin
    frozen  = mem_busy || exec_busy;
    redir   = !frozen && (redirect_valid || pend_v);
    lwstall = memread_e && regwrite_e && (match(rs0_d, rd_e) || match(rs1_d, rd_e));
    lw      = !frozen && !redir && lwstall;
    run     = !frozen && !redir && !lwstall;
    stalled = frozen || lw;
  end
  always_comb begin
    fetch_en     = rstn && (redir || run);
    decode_en    = rstn && (redir || run);
    exec_en      = rstn && !frozen;
    mem_en       = rstn && !mem_busy;
    decode_flush = !rstn || redir;
    exec_flush   = !rstn || redir || lw;
    mem_bubble   = !rstn || (!mem_busy && exec_busy);
    wb_bubble    = !rstn || mem_busy;
    forward0     = rstn ? fwd(rs0_d) : 2'b00;
    forward1     = rstn ? fwd(rs1_d) : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc        <= RESET_PC;
      pend_v    <= 1'b0;
      pend_pc   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (frozen && redirect_valid) begin
        pend_v  <= 1'b1;
        pend_pc <= redirect_pc;
      end
      if (redir) begin
        pc     <= redirect_valid ? redirect_pc : pend_pc;
        pend_v <= 1'b0;
      end else if (run) begin
        pc <= pc + PCW'(PC_STEP);
      end
      if (stalled && !(&stall_cnt)) stall_cnt <= stall_cnt + CNTW'(1);
      if (redir && !(&flush_cnt)) flush_cnt <= flush_cnt + CNTW'(1);
    end
  end
endmodule
